// File: rtl/compound_port_arbiter_pkg.sv
// Shared definitions for the compound port arbiter: FSM phases and the
// modulo helper used for round-robin index arithmetic.
package compound_arb_types;

  typedef enum logic [1:0] {
    arb_idle  = 2'd0,
    arb_read  = 2'd1,
    arb_write = 2'd2
  } ArbPhases;

  // Folds an index in [0, 2*n-1) back into [0, n); n need not be a power of two.
  function automatic int rr_wrap(input int idx, input int n);
    return (idx >= n) ? (idx - n) : idx;
  endfunction

endpackage

// File: rtl/top_level_types_pkg.sv
// Project-wide payload type carried between generated module ports.
package top_level_types;

  typedef struct packed {
    logic [15:0] addr;
    logic [31:0] data;
    logic [3:0]  tag;
  } CompoundType;

endpackage

// File: rtl/compound_port_arbiter_rr_pick.sv
// Combinational round-robin picker: first asserted request at or after
// rr_ptr, searching upward with wrap at NUM_REQ-1.
module rr_pick
  import compound_arb_types::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    rr_ptr,
  output logic [ID_W-1:0]    winner,
  output logic               any_valid
);

  int idx;

  always_comb begin
    winner    = '0;
    any_valid = 1'b0;
    idx       = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = rr_wrap(int'(rr_ptr) + k, NUM_REQ);
      if (!any_valid && req[idx]) begin
        any_valid = 1'b1;
        winner    = ID_W'(idx);
      end
    end
  end

endmodule

// File: rtl/compound_port_arbiter.sv
// Round-robin arbiter funnelling NUM_REQ sync/notify producers into one
// blocking CompoundType port, buffering one transaction tagged with its source.
module compound_port_arbiter
  import top_level_types::*;
  import compound_arb_types::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  CompoundType [NUM_REQ-1:0] req_in,
  input  logic [NUM_REQ-1:0]       req_in_sync,
  output logic [NUM_REQ-1:0]       req_in_notify,
  output CompoundType              arb_out,
  output logic [ID_W-1:0]          arb_out_id,
  input  logic                     arb_out_sync,
  output logic                     arb_out_notify,
  output logic                     busy
);

  ArbPhases           state_q, state_d;
  logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]    grant_q, grant_d;
  logic [NUM_REQ-1:0] req_in_notify_q, req_in_notify_d;
  CompoundType        arb_out_q, arb_out_d;
  logic [ID_W-1:0]    arb_out_id_q, arb_out_id_d;
  logic               arb_out_notify_q, arb_out_notify_d;
  logic               busy_q, busy_d;

  logic [ID_W-1:0]    winner;
  logic               any_valid;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr_pick (
    .req       (req_in_sync),
    .rr_ptr    (rr_ptr_q),
    .winner    (winner),
    .any_valid (any_valid)
  );

  always_comb begin
    state_d          = state_q;
    rr_ptr_d         = rr_ptr_q;
    grant_d          = grant_q;
    req_in_notify_d  = req_in_notify_q;
    arb_out_d        = arb_out_q;
    arb_out_id_d     = arb_out_id_q;
    arb_out_notify_d = arb_out_notify_q;
    busy_d           = busy_q;

    unique case (state_q)
      arb_idle: begin
        if (any_valid) begin
          grant_d         = winner;
          req_in_notify_d = NUM_REQ'(1) << winner;
          busy_d          = 1'b1;
          state_d         = arb_read;
        end
      end

      arb_read: begin
        req_in_notify_d = '0;
        if (req_in_sync[grant_q]) begin
          arb_out_d        = req_in[grant_q];
          arb_out_id_d     = grant_q;
          arb_out_notify_d = 1'b1;
          state_d          = arb_write;
        end else begin
          // Producer withdrew: abandon the grant without advancing fairness.
          busy_d  = 1'b0;
          state_d = arb_idle;
        end
      end

      arb_write: begin
        if (arb_out_sync) begin
          arb_out_notify_d = 1'b0;
          busy_d           = 1'b0;
          rr_ptr_d         = ID_W'(rr_wrap(int'(grant_q) + 1, NUM_REQ));
          state_d          = arb_idle;
        end
      end

      default: begin
        state_d         = arb_idle;
        req_in_notify_d = '0;
        busy_d          = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= arb_idle;
      rr_ptr_q         <= '0;
      grant_q          <= '0;
      req_in_notify_q  <= '0;
      arb_out_q        <= '0;
      arb_out_id_q     <= '0;
      arb_out_notify_q <= 1'b0;
      busy_q           <= 1'b0;
    end else begin
      state_q          <= state_d;
      rr_ptr_q         <= rr_ptr_d;
      grant_q          <= grant_d;
      req_in_notify_q  <= req_in_notify_d;
      arb_out_q        <= arb_out_d;
      arb_out_id_q     <= arb_out_id_d;
      arb_out_notify_q <= arb_out_notify_d;
      busy_q           <= busy_d;
    end
  end

  assign req_in_notify  = req_in_notify_q;
  assign arb_out        = arb_out_q;
  assign arb_out_id     = arb_out_id_q;
  assign arb_out_notify = arb_out_notify_q;
  assign busy           = busy_q;

endmodule

// File: tb/tb_compound_port_arbiter.sv
// Directed bench for compound_port_arbiter: a 4-requester and a 3-requester
// instance share clock and reset; each task drives one scenario.
module tb_compound_port_arbiter;
  import top_level_types::*;

  logic clk = 1'b0;
  logic rst = 1'b1;

  CompoundType [3:0] req_in4;
  logic [3:0]        sync4;
  logic [3:0]        notify4;
  CompoundType       out4;
  logic [1:0]        id4;
  logic              osync4;
  logic              onotify4;
  logic              busy4;

  CompoundType [2:0] req_in3;
  logic [2:0]        sync3;
  logic [2:0]        notify3;
  CompoundType       out3;
  logic [1:0]        id3;
  logic              osync3;
  logic              onotify3;
  logic              busy3;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  compound_port_arbiter #(.NUM_REQ(4)) dut4 (
    .clk            (clk),
    .rst            (rst),
    .req_in         (req_in4),
    .req_in_sync    (sync4),
    .req_in_notify  (notify4),
    .arb_out        (out4),
    .arb_out_id     (id4),
    .arb_out_sync   (osync4),
    .arb_out_notify (onotify4),
    .busy           (busy4)
  );

  compound_port_arbiter #(.NUM_REQ(3)) dut3 (
    .clk            (clk),
    .rst            (rst),
    .req_in         (req_in3),
    .req_in_sync    (sync3),
    .req_in_notify  (notify3),
    .arb_out        (out3),
    .arb_out_id     (id3),
    .arb_out_sync   (osync3),
    .arb_out_notify (onotify3),
    .busy           (busy3)
  );

  function automatic CompoundType mk(input int i, input int salt);
    CompoundType c;
    c.addr = 16'(16'h1000 + i * 16 + salt);
    c.data = 32'hC0DE0000 ^ 32'(i * 4096 + salt * 17);
    c.tag  = 4'(i + salt);
    return c;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst    = 1'b1;
    sync4  = '0;
    sync3  = '0;
    osync4 = 1'b0;
    osync3 = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst    = 1'b1;
    sync4  = '0;
    sync3  = '0;
    osync4 = 1'b0;
    osync3 = 1'b0;
    step();
    step();
    n_checks++; if (notify4 !== 4'b0000) begin n_fail++; $display("FAIL reset_notify4: got %b want 0000", notify4); end
    n_checks++; if (onotify4 !== 1'b0) begin n_fail++; $display("FAIL reset_out_notify4: got %b want 0", onotify4); end
    n_checks++; if (out4 !== CompoundType'(0)) begin n_fail++; $display("FAIL reset_out4: got %h want 0", out4); end
    n_checks++; if (id4 !== 2'd0) begin n_fail++; $display("FAIL reset_id4: got %0d want 0", id4); end
    n_checks++; if (busy4 !== 1'b0) begin n_fail++; $display("FAIL reset_busy4: got %b want 0", busy4); end
    n_checks++; if (notify3 !== 3'b000) begin n_fail++; $display("FAIL reset_notify3: got %b want 000", notify3); end
    n_checks++; if (busy3 !== 1'b0) begin n_fail++; $display("FAIL reset_busy3: got %b want 0", busy3); end
    rst = 1'b0;
  endtask

  task automatic test_single();
    do_reset();
    for (int i = 0; i < 4; i++) req_in4[i] = mk(i, 1);
    osync4 = 1'b1;
    sync4  = 4'b0100;
    step();
    n_checks++; if (notify4 !== 4'b0100) begin n_fail++; $display("FAIL single_notify_t1: got %b want 0100", notify4); end
    n_checks++; if (onotify4 !== 1'b0) begin n_fail++; $display("FAIL single_out_notify_t1: got %b want 0", onotify4); end
    n_checks++; if (busy4 !== 1'b1) begin n_fail++; $display("FAIL single_busy_t1: got %b want 1", busy4); end
    req_in4[2] = mk(2, 7);
    step();
    sync4 = 4'b0000;
    n_checks++; if (notify4 !== 4'b0000) begin n_fail++; $display("FAIL single_notify_t2: got %b want 0000", notify4); end
    n_checks++; if (onotify4 !== 1'b1) begin n_fail++; $display("FAIL single_out_notify_t2: got %b want 1", onotify4); end
    n_checks++; if (id4 !== 2'd2) begin n_fail++; $display("FAIL single_id: got %0d want 2", id4); end
    n_checks++; if (out4 !== mk(2, 7)) begin n_fail++; $display("FAIL single_payload: got %h want %h", out4, mk(2, 7)); end
    step();
    n_checks++; if (onotify4 !== 1'b0) begin n_fail++; $display("FAIL single_out_notify_t3: got %b want 0", onotify4); end
    n_checks++; if (busy4 !== 1'b0) begin n_fail++; $display("FAIL single_busy_t3: got %b want 0", busy4); end
    n_checks++; if (out4 !== mk(2, 7)) begin n_fail++; $display("FAIL single_retain: got %h want %h", out4, mk(2, 7)); end
    osync4 = 1'b0;
  endtask

  task automatic test_round_robin();
    int ids[$];
    int last_c;
    do_reset();
    for (int i = 0; i < 4; i++) req_in4[i] = mk(i, 0);
    osync4 = 1'b1;
    sync4  = 4'b1111;
    last_c = -1;
    for (int c = 0; c < 40 && ids.size() < 6; c++) begin
      n_checks++; if ($countones(notify4) > 1) begin n_fail++; $display("FAIL rr_onehot: got %b want at most one bit", notify4); end
      if (onotify4 && osync4) begin
        ids.push_back(int'(id4));
        n_checks++; if (out4 !== mk(int'(id4), 0)) begin n_fail++; $display("FAIL rr_payload: got %h want %h", out4, mk(int'(id4), 0)); end
        if (last_c >= 0) begin
          n_checks++; if (c - last_c != 3) begin n_fail++; $display("FAIL rr_spacing: got %0d want 3", c - last_c); end
        end
        last_c = c;
      end
      step();
    end
    n_checks++; if (ids.size() != 6) begin n_fail++; $display("FAIL rr_count: got %0d want 6", ids.size()); end
    for (int k = 0; k < ids.size(); k++) begin
      n_checks++; if (ids[k] != k % 4) begin n_fail++; $display("FAIL rr_order[%0d]: got %0d want %0d", k, ids[k], k % 4); end
    end
    sync4  = '0;
    osync4 = 1'b0;
  endtask

  task automatic test_stall();
    do_reset();
    for (int i = 0; i < 4; i++) req_in4[i] = mk(i, 5);
    osync4 = 1'b0;
    sync4  = 4'b0010;
    step();
    step();
    sync4 = 4'b0000;
    for (int c = 0; c < 10; c++) begin
      step();
      n_checks++; if (out4 !== mk(1, 5) || id4 !== 2'd1) begin n_fail++; $display("FAIL stall_hold[%0d]: got %h/%0d want %h/1", c, out4, id4, mk(1, 5)); end
      n_checks++; if (onotify4 !== 1'b1 || busy4 !== 1'b1 || notify4 !== 4'b0000) begin n_fail++; $display("FAIL stall_ctrl[%0d]: got on=%b busy=%b rn=%b want 1 1 0000", c, onotify4, busy4, notify4); end
    end
    osync4 = 1'b1;
    step();
    osync4 = 1'b0;
    n_checks++; if (onotify4 !== 1'b0 || busy4 !== 1'b0) begin n_fail++; $display("FAIL stall_release: got on=%b busy=%b want 0 0", onotify4, busy4); end
    n_checks++; if (out4 !== mk(1, 5)) begin n_fail++; $display("FAIL stall_retain: got %h want %h", out4, mk(1, 5)); end
  endtask

  task automatic test_withdraw();
    do_reset();
    for (int i = 0; i < 4; i++) req_in4[i] = mk(i, 9);
    osync4 = 1'b1;
    sync4  = 4'b0010;
    step();
    n_checks++; if (notify4 !== 4'b0010) begin n_fail++; $display("FAIL wd_notify_t1: got %b want 0010", notify4); end
    sync4 = 4'b0000;
    step();
    n_checks++; if (notify4 !== 4'b0000 || busy4 !== 1'b0 || onotify4 !== 1'b0) begin n_fail++; $display("FAIL wd_idle: got rn=%b busy=%b on=%b want 0000 0 0", notify4, busy4, onotify4); end
    n_checks++; if (out4 !== CompoundType'(0)) begin n_fail++; $display("FAIL wd_no_capture: got %h want 0", out4); end
    sync4 = 4'b0011;
    step();
    n_checks++; if (notify4 !== 4'b0001) begin n_fail++; $display("FAIL wd_ptr_kept: got %b want 0001", notify4); end
    sync4  = '0;
    osync4 = 1'b0;
  endtask

  task automatic test_wrap3();
    int ids[$];
    do_reset();
    for (int i = 0; i < 3; i++) req_in3[i] = mk(i, 3);
    osync3 = 1'b1;
    sync3  = 3'b010;
    step();
    step();
    sync3 = 3'b101;
    for (int c = 0; c < 20 && ids.size() < 3; c++) begin
      n_checks++; if (id3 > 2'd2) begin n_fail++; $display("FAIL wrap_id_range: got %0d want <3", id3); end
      if (onotify3 && osync3) ids.push_back(int'(id3));
      step();
    end
    n_checks++; if (ids.size() != 3) begin n_fail++; $display("FAIL wrap_count: got %0d want 3", ids.size()); end
    if (ids.size() == 3) begin
      n_checks++; if (ids[0] != 1 || ids[1] != 2 || ids[2] != 0) begin n_fail++; $display("FAIL wrap_order: got %0d,%0d,%0d want 1,2,0", ids[0], ids[1], ids[2]); end
    end
    sync3  = '0;
    osync3 = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 4; i++) req_in4[i] = mk(i, 11);
    osync4 = 1'b0;
    sync4  = 4'b1000;
    step();
    step();
    n_checks++; if (onotify4 !== 1'b1 || busy4 !== 1'b1 || id4 !== 2'd3) begin n_fail++; $display("FAIL rmid_pre: got on=%b busy=%b id=%0d want 1 1 3", onotify4, busy4, id4); end
    rst   = 1'b1;
    sync4 = 4'b1010;
    #1;
    n_checks++; if (onotify4 !== 1'b0 || busy4 !== 1'b0 || notify4 !== 4'b0000) begin n_fail++; $display("FAIL rmid_async: got on=%b busy=%b rn=%b want 0 0 0000", onotify4, busy4, notify4); end
    n_checks++; if (out4 !== CompoundType'(0) || id4 !== 2'd0) begin n_fail++; $display("FAIL rmid_data: got %h/%0d want 0/0", out4, id4); end
    #1;
    rst = 1'b0;
    step();
    n_checks++; if (notify4 !== 4'b0010) begin n_fail++; $display("FAIL rmid_ptr0: got %b want 0010", notify4); end
    sync4 = '0;
  endtask

  initial begin
    req_in4 = '0;
    req_in3 = '0;
    sync4   = '0;
    sync3   = '0;
    osync4  = 1'b0;
    osync3  = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_stall();
    test_withdraw();
    test_wrap3();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/compound_port_arbiter.md
# compound_port_arbiter

Round-robin arbiter sharing one blocking CompoundType output port among NUM_REQ blocking-port producers, using the same sync/notify handshake as the generated module skeletons. It sits between several producer modules and a single consumer port (e.g. a b_in port of a downstream module), buffers exactly one transaction, and tags it with the source index. Fairness is strict round-robin over completed transfers.

## Interface
- NUM_REQ, 4, number of requesters (2..16)
- ID_W, $clog2(NUM_REQ), width of source id
- clk  input  1  clock
- rst  input  1  reset: rst, asynchronous, active-high; clock clk
- req_in  input  NUM_REQ x CompoundType  per-requester payload
- req_in_sync  input  NUM_REQ  requester i has valid payload
- req_in_notify  output  NUM_REQ  arbiter accepts from requester i
- arb_out  output  CompoundType  buffered payload
- arb_out_id  output  ID_W  index of requester that supplied arb_out
- arb_out_sync  input  1  consumer ready
- arb_out_notify  output  1  arbiter offers arb_out
- busy  output  1  state != arb_idle

## Operation
- Transfer rule: input i transfers in a cycle where req_in_sync[i] && req_in_notify[i]; output transfers where arb_out_sync && arb_out_notify.
- All outputs registered. Reset values: req_in_notify all 0, arb_out_notify 0, arb_out all-zero, arb_out_id 0, busy 0, state arb_idle, rr_ptr 0, grant 0.
- States: arb_idle, arb_read, arb_write.
- arb_idle: if req_in_sync != 0, pick winner w = first index with sync high searching rr_ptr, rr_ptr+1, ... modulo NUM_REQ; grant <= w; req_in_notify[w] <= 1; busy <= 1; -> arb_read. Else stay.
- arb_read: if req_in_sync[grant]: arb_out <= req_in[grant], arb_out_id <= grant, req_in_notify <= 0, arb_out_notify <= 1 -> arb_write. Else (requester withdrew): req_in_notify <= 0, busy <= 0, rr_ptr unchanged -> arb_idle.
- arb_write: hold arb_out/arb_out_id stable. On arb_out_sync: arb_out_notify <= 0, busy <= 0, rr_ptr <= (grant == NUM_REQ-1) ? 0 : grant+1 -> arb_idle. Else stay indefinitely.
- At most one req_in_notify bit high at any time; never high outside arb_read.
- arb_out retains last value after transfer (not cleared).
- NUM_REQ not power of two: pointer wraps explicitly at NUM_REQ-1; ids >= NUM_REQ never produced.

## Timing
- Requester sync sampled in cycle t (idle) -> notify visible t+1 -> payload captured at end of t+1 -> arb_out_notify visible t+2 -> with consumer ready, output transfer in t+2, back in arb_idle at t+3.
- Minimum 3 cycles per transaction; throughput 1 per 3 cycles.
- Consumer stall extends arb_write without limit; no input is accepted meanwhile.
- Simultaneous requests: only the round-robin winner advances; others keep sync high and wait.
- Withdrawal in arb_read costs 2 cycles, no output, no pointer update.
- rst mid-operation (any state): buffered transaction discarded, all outputs to reset values asynchronously, pointer to 0.

## Structure
- Shared package compound_arb_types: typedef enum ArbPhases {arb_idle, arb_read, arb_write}. CompoundType is taken from top_level_types.
- Sub-module rr_pick: combinational, inputs req vector and rr_ptr, outputs winner index and any-valid flag; parameterized by NUM_REQ.

## Test plan
- Single requester: NUM_REQ=4, sync[2]=1 at t -> notify[2] high t+1 only, arb_out_notify high t+2, arb_out_id=2, arb_out equals req_in[2] captured at t+1.
- All four requesters held high, consumer always ready -> arb_out_id sequence 0,1,2,3,0,1 with one output every 3 cycles.
- Consumer stall: arb_out_sync low for 10 cycles -> arb_out/arb_out_id stable, notify held, all req_in_notify 0, busy 1; transfer on first sync-high cycle.
- Withdrawal: sync[1] high at t, low at t+1 -> no capture, back to arb_idle at t+2, rr_ptr still 0 (next grant for sync[0|1] picks 0).
- NUM_REQ=3 wrap: requesters 2 and 0 active, rr_ptr=2 -> grant 2 then 0, id never 3.
- Reset asserted during arb_write -> arb_out_notify, busy, req_in_notify drop immediately; after release, first grant starts search at index 0.
